// File: rtl/eng_share_arbiter.sv
// Round-robin arbiter that shares one start/done accelerator engine among NREQ
// requesters, with operand latching, result return and a WAIT-state watchdog.
module eng_share_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int TMO  = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      op_x,
  input  logic [NREQ*DW-1:0]      op_u,
  output logic [NREQ-1:0]         ack,
  output logic [NREQ-1:0]         err,
  output logic [DW-1:0]           res_o,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic                    busy,
  output logic                    eng_start,
  output logic [DW-1:0]           eng_x,
  output logic [DW-1:0]           eng_u,
  input  logic                    eng_done,
  input  logic [DW-1:0]           eng_res
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = 16;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [NREQ-1:0] ack_q, ack_d, err_q, err_d;
  logic [DW-1:0]   res_q, res_d, eng_x_q, eng_x_d, eng_u_q, eng_u_d;
  logic [IW-1:0]   gnt_id_q, gnt_id_d;
  logic            busy_q, busy_d, eng_start_q, eng_start_d;

  logic            found;
  logic [IW-1:0]   win, cand;
  logic [NREQ-1:0] gnt_oh;
  logic            timeout;

  // Rotating search starting just after the last served client.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    cand  = ptr_q;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign gnt_oh  = NREQ'(1) << gnt_id_q;
  assign timeout = (timer_q == TW'(TMO - 1));

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (found) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (eng_done || timeout) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath logic: values are computed one state early so every output is a flop.
  always_comb begin
    ptr_d       = ptr_q;
    timer_d     = timer_q;
    gnt_id_d    = gnt_id_q;
    eng_x_d     = eng_x_q;
    eng_u_d     = eng_u_q;
    res_d       = res_q;
    ack_d       = '0;
    err_d       = '0;
    eng_start_d = 1'b0;
    busy_d      = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_id_d    = win;
          eng_x_d     = op_x[int'(win)*DW +: DW];
          eng_u_d     = op_u[int'(win)*DW +: DW];
          timer_d     = '0;
          eng_start_d = 1'b1;
        end
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        // Done wins over a coincident timeout.
        if (eng_done) begin
          res_d = eng_res;
          ack_d = gnt_oh;
        end else if (timeout) begin
          res_d = '0;
          ack_d = gnt_oh;
          err_d = gnt_oh;
        end
      end
      S_RESP:  ptr_d = gnt_id_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= IW'(NREQ - 1);
      timer_q     <= '0;
      gnt_id_q    <= '0;
      eng_x_q     <= '0;
      eng_u_q     <= '0;
      res_q       <= '0;
      ack_q       <= '0;
      err_q       <= '0;
      eng_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      timer_q     <= timer_d;
      gnt_id_q    <= gnt_id_d;
      eng_x_q     <= eng_x_d;
      eng_u_q     <= eng_u_d;
      res_q       <= res_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      eng_start_q <= eng_start_d;
      busy_q      <= busy_d;
    end
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign res_o     = res_q;
  assign gnt_id    = gnt_id_q;
  assign busy      = busy_q;
  assign eng_start = eng_start_q;
  assign eng_x     = eng_x_q;
  assign eng_u     = eng_u_q;

endmodule

// File: tb/tb_eng_share_arbiter.sv
// Directed, table-driven bench for eng_share_arbiter (NREQ=4, DW=16, TMO=8).
module tb_eng_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] op_x, op_u;
  logic [3:0]  ack, err;
  logic [15:0] res_o;
  logic [1:0]  gnt_id;
  logic        busy, eng_start;
  logic [15:0] eng_x, eng_u;
  logic        eng_done;
  logic [15:0] eng_res;

  int n_vec  = 0;
  int n_miss = 0;

  eng_share_arbiter #(.NREQ(4), .DW(16), .TMO(8)) dut (
    .clk(clk), .rst(rst), .req(req), .op_x(op_x), .op_u(op_u),
    .ack(ack), .err(err), .res_o(res_o), .gnt_id(gnt_id), .busy(busy),
    .eng_start(eng_start), .eng_x(eng_x), .eng_u(eng_u),
    .eng_done(eng_done), .eng_res(eng_res)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got hung expected finish");
    $fatal(1, "bench time limit");
  end

  typedef struct {
    logic [3:0]  req;
    logic [15:0] x, u;
    int          done_w;   // WAIT cycle index at which done is driven, -1 = never
    logic [15:0] res;
    logic [1:0]  gnt;
    logic [15:0] ex, eu;
    logic [3:0]  ack, err;
    logic [15:0] eres;
    int          waits;    // WAIT cycles before RESP
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    eng_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Operand slot i carries the client index in its top nibble.
  task automatic fill_ops(input logic [15:0] x, input logic [15:0] u);
    for (int i = 0; i < 4; i++) begin
      op_x[i*16 +: 16] = {4'(i), x[11:0]};
      op_u[i*16 +: 16] = {4'(i), u[11:0]};
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int waits;
    req = v.req;
    fill_ops(v.x, v.u);
    eng_res = v.res;
    tick();
    check({tag, "_start"}, 32'(eng_start), 32'd1);
    check({tag, "_gnt"}, 32'(gnt_id), 32'(v.gnt));
    check({tag, "_x"}, 32'(eng_x), 32'(v.ex));
    check({tag, "_u"}, 32'(eng_u), 32'(v.eu));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    op_x = {4{16'hDEAD}};
    op_u = {4{16'hBEEF}};
    tick();
    check({tag, "_start_1cyc"}, 32'(eng_start), 32'd0);
    waits = -1;
    for (int w = 0; w < 30; w++) begin
      eng_done = (w == v.done_w);
      tick();
      eng_done = 1'b0;
      if (ack != 4'b0) begin
        waits = w + 1;
        break;
      end
      check({tag, "_x_hold"}, 32'(eng_x), 32'(v.ex));
    end
    check({tag, "_waits"}, 32'(waits), 32'(v.waits));
    check({tag, "_ack"}, 32'(ack), 32'(v.ack));
    check({tag, "_err"}, 32'(err), 32'(v.err));
    check({tag, "_res"}, 32'(res_o), 32'(v.eres));
    req = '0;
    tick();
    check({tag, "_ack_clr"}, 32'({ack, err}), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  vec_t tv[8];
  vec_t vr;
  int   ord[5];
  int   exp_ord[5];
  int   n_ack, multi, pend;

  initial begin
    tv[0] = '{4'b0001, 16'h0003, 16'h0005,  3, 16'h000F, 2'd0, 16'h0003, 16'h0005, 4'b0001, 4'b0000, 16'h000F, 4};
    tv[1] = '{4'b0100, 16'h0123, 16'h0456,  0, 16'hABCD, 2'd2, 16'h2123, 16'h2456, 4'b0100, 4'b0000, 16'hABCD, 1};
    tv[2] = '{4'b0101, 16'h0111, 16'h0222,  1, 16'h1234, 2'd0, 16'h0111, 16'h0222, 4'b0001, 4'b0000, 16'h1234, 2};
    tv[3] = '{4'b0101, 16'h0AAA, 16'h0BBB,  2, 16'h5555, 2'd2, 16'h2AAA, 16'h2BBB, 4'b0100, 4'b0000, 16'h5555, 3};
    tv[4] = '{4'b1000, 16'h0FFF, 16'h0EEE, -1, 16'h9999, 2'd3, 16'h3FFF, 16'h3EEE, 4'b1000, 4'b1000, 16'h0000, 8};
    tv[5] = '{4'b0010, 16'h0042, 16'h0024,  2, 16'h0066, 2'd1, 16'h1042, 16'h1024, 4'b0010, 4'b0000, 16'h0066, 3};
    tv[6] = '{4'b1000, 16'h0001, 16'h0002,  7, 16'hBEEF, 2'd3, 16'h3001, 16'h3002, 4'b1000, 4'b0000, 16'hBEEF, 8};
    tv[7] = '{4'b1111, 16'h0777, 16'h0888,  0, 16'h7777, 2'd0, 16'h0777, 16'h0888, 4'b0001, 4'b0000, 16'h7777, 1};

    op_x = '0; op_u = '0; eng_res = '0;
    do_reset();
    check("rst_outputs", {ack, err, gnt_id, busy, eng_start}, 32'd0);
    check("rst_res", 32'(res_o), 32'd0);
    check("rst_eng_ops", {eng_x, eng_u}, 32'd0);

    for (int i = 0; i < 8; i++) run_vec(tv[i], $sformatf("vec%0d", i));

    // Spurious done in IDLE and START, then the client withdraws during WAIT.
    eng_res = 16'h1111;
    eng_done = 1'b1;
    tick();
    check("spur_idle", {busy, eng_start, ack}, 32'd0);
    req = 4'b0001;
    fill_ops(16'h0050, 16'h0060);
    tick();
    check("spur_start_pulse", 32'(eng_start), 32'd1);
    tick();
    eng_done = 1'b0;
    check("spur_start_ignored", {busy, ack}, {27'd0, 1'b1, 4'b0000});
    req = 4'b0000;
    tick();
    tick();
    check("withdraw_no_ack", 32'(ack), 32'd0);
    eng_res = 16'h2222;
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    check("withdraw_ack", 32'(ack), 32'b0001);
    check("withdraw_res", 32'(res_o), 32'h2222);
    tick();

    // Asynchronous reset between edges while in WAIT.
    req = 4'b0100;
    op_x = {4{16'h5A5A}};
    op_u = {4{16'hA5A5}};
    tick();
    tick();
    check("arst_pre_busy", {busy, eng_x}, {15'd0, 1'b1, 16'h5A5A});
    #3 rst = 1'b1;
    #1;
    check("arst_outputs", {ack, err, gnt_id, busy, eng_start}, 32'd0);
    check("arst_ops", {eng_x, eng_u}, 32'd0);
    check("arst_res", 32'(res_o), 32'd0);
    req = '0;
    tick();
    eng_done = 1'b1;
    #2 rst = 1'b0;
    tick();
    eng_done = 1'b0;
    check("arst_stale_done", {busy, ack}, 32'd0);
    vr = '{4'b0010, 16'h0321, 16'h0654, 1, 16'h0BAD, 2'd1, 16'h1321, 16'h1654, 4'b0010, 4'b0000, 16'h0BAD, 2};
    run_vec(vr, "post_rst");

    // Round-robin with all requests held; engine answers on the first WAIT cycle.
    do_reset();
    exp_ord = '{0, 1, 2, 3, 0};
    n_ack = 0; multi = 0; pend = 0;
    req = 4'b1111;
    eng_res = 16'h4242;
    for (int c = 0; c < 100 && n_ack < 5; c++) begin
      tick();
      if ($countones(ack) > 1) multi++;
      if (ack != 4'b0) begin
        for (int b = 0; b < 4; b++) if (ack[b]) ord[n_ack] = b;
        n_ack++;
      end
      eng_done = pend[0];
      pend = int'(eng_start);
    end
    eng_done = 1'b0;
    req = '0;
    check("rr_ack_count", 32'(n_ack), 32'd5);
    check("rr_multi_ack", 32'(multi), 32'd0);
    for (int k = 0; k < n_ack; k++) check($sformatf("rr_order%0d", k), 32'(ord[k]), 32'(exp_ord[k]));
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/eng_share_arbiter.md
Name: eng_share_arbiter

Overview:
- Shares one accelerator engine (start/done handshake, X/U operands, single result) among NREQ independent requesters.
- Round-robin arbitration; latches the winner's operands, sequences the engine, returns the result with a one-cycle ack to the winner.
- A watchdog aborts engine runs that never signal done.
- Sits between the per-client wrapper controllers and the single engine instance.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 16, operand/result width
- TMO, 255, max cycles in WAIT before abort (1..65535)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  request per client, level, held until that client's ack
- op_x  in  NREQ*DW  X operands, client i at [i*DW +: DW]
- op_u  in  NREQ*DW  U operands, same packing
- ack  out  NREQ  one-cycle completion pulse to served client
- err  out  NREQ  one-cycle timeout flag, coincident with ack
- res_o  out  DW  result, valid only while ack is nonzero
- gnt_id  out  clog2(NREQ)  index of client currently being served
- busy  out  1  high in every state except IDLE
- eng_start  out  1  one-cycle engine start pulse
- eng_x  out  DW  latched X to engine, stable from START through WAIT
- eng_u  out  DW  latched U to engine, stable from START through WAIT
- eng_done  in  1  engine completion, sampled only in WAIT
- eng_res  in  DW  engine result, valid with eng_done

Behaviour:
- Reset values:
  - state=IDLE.
  - ack, err, res_o, eng_start, busy, eng_x, eng_u, gnt_id, timer = 0.
  - Priority pointer ptr=NREQ-1, so client 0 has first priority.
- Reset mid-operation aborts immediately. No ack is issued. The engine is not notified; a stale eng_done after reset is ignored because it arrives outside WAIT.
- FSM states: IDLE, START, WAIT, RESP. All outputs are registered.
- IDLE:
  - If any req bit is set, pick the first set bit searching ptr+1, ptr+2, ... modulo NREQ.
  - Latch gnt_id, eng_x and eng_u from that client; clear timer; go to START.
  - If no req bit is set, stay in IDLE.
- START: eng_start=1 for exactly this cycle; go to WAIT.
- WAIT:
  - timer increments each cycle.
  - If eng_done=1: latch res_o<=eng_res; go to RESP with err clear.
  - Else if timer==TMO-1: res_o<=0, timeout flag set; go to RESP.
  - If eng_done and the timeout coincide in the same cycle, done wins and err stays 0.
- RESP:
  - ack[gnt_id]=1, and err[gnt_id]=timeout flag, for this cycle only.
  - ptr<=gnt_id; go to IDLE.
- Latency:
  - req seen in IDLE at cycle 0 → eng_start at cycle 1.
  - eng_done at cycle k → ack at cycle k+1.
  - Minimum req-to-ack is 3 cycles (done at cycle 2).
- Request rules:
  - A client drops req on the cycle after its ack. If req is still high in the IDLE cycle following RESP, it is re-arbitrated as a new request, at lowest priority because ptr now points to it.
  - If a client drops req while being served, the operation still completes and ack is still pulsed.
  - Operand changes after the IDLE latch cycle have no effect.
- Fairness: with all requests continuously asserted, service order is 0,1,…,NREQ-1,0,… and no client waits more than NREQ-1 services.
- eng_done while not in WAIT (IDLE, START, RESP) is ignored.
- At most one ack bit is high in any cycle; ack and err are never high outside RESP.

Test Plan:
- Single request: after reset, req=0001, op_x[0]=0x0003, op_u[0]=0x0005, engine model asserts done 4 cycles after start with eng_res=0x000F → eng_start one cycle at cycle 1; eng_x=3 and eng_u=5 held through WAIT; ack=0001 with res_o=0x000F exactly one cycle after done; busy low again next cycle.
- Round-robin: req=1111 held, each client re-asserts after its ack → grant order 0,1,2,3,0; five acks in that order; never two ack bits high in the same cycle.
- Priority rotation: after client 2 is served, req=0101 → client 0 is granted before client 2.
- Timeout: TMO=8, engine never asserts done → ack=0001 and err=0001 on the same cycle, 9 cycles after eng_start; res_o=0; next request is served normally. Separately, done and the timeout in the same WAIT cycle → err=0 and res_o=eng_res.
- Spurious done and withdrawn request: eng_done pulsed in IDLE and in START → ignored, no state change. Client drops req during WAIT → ack still pulsed on completion.
- Async reset mid-WAIT: assert rst between clock edges → all outputs 0 immediately; no ack; a following req=0010 is served with client 1 granted (ptr reset).
